// File: rtl/mmio_dump_initiator.sv
// End-of-test MMIO initiator: dumps int/FP registers over a req/gnt bus,
// then writes the stop signal; also issues trap-signal writes on request.
module mmio_dump_initiator #(
  parameter bit          DUMP_FP        = 1'b1,
  parameter logic [31:0] ADDR_STOP_SIG  = 32'h6000_0000,
  parameter logic [31:0] ADDR_TRAP_SIG  = 32'h6000_0008,
  parameter logic [31:0] ADDR_REG_DUMP  = 32'h6000_0010,
  parameter logic [31:0] ADDR_FREG_DUMP = 32'h6000_0018
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trap_i,
  input  logic [63:0] trap_cause_i,
  output logic [4:0]  xrf_raddr_o,
  input  logic [63:0] xrf_rdata_i,
  output logic [4:0]  frf_raddr_o,
  input  logic [63:0] frf_rdata_i,
  output logic        mmio_req_o,
  input  logic        mmio_gnt_i,
  output logic        mmio_we_o,
  output logic [31:0] mmio_addr_o,
  output logic [7:0]  mmio_strb_o,
  output logic [63:0] mmio_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE, XRD, XWR, FRD, FWR, STOP, TRAP, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q;
  logic        start_pend_q;
  logic        trap_pend_q;
  logic        cap_vld_q;
  logic [63:0] wdata_q;
  logic [63:0] cause_q;
  logic [63:0] cause_pend_q;
  logic        go_trap;
  logic        go_start;
  logic        last_idx;

  assign go_trap  = trap_i | trap_pend_q;
  assign go_start = start_i | start_pend_q;
  assign last_idx = (idx_q == 5'd31);

  always_comb begin
    state_d      = state_q;
    mmio_req_o   = 1'b0;
    mmio_addr_o  = 32'h0;
    mmio_wdata_o = 64'h0;
    xrf_raddr_o  = 5'd0;
    frf_raddr_o  = 5'd0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_trap)       state_d = TRAP;
        else if (go_start) state_d = XRD;
      end
      XRD: begin
        busy_o      = 1'b1;
        xrf_raddr_o = idx_q;
        state_d     = XWR;
      end
      XWR: begin
        busy_o       = 1'b1;
        xrf_raddr_o  = idx_q;
        mmio_req_o   = 1'b1;
        mmio_addr_o  = ADDR_REG_DUMP;
        // read data arrives this cycle; the registered copy covers stalls
        mmio_wdata_o = cap_vld_q ? wdata_q : xrf_rdata_i;
        if (mmio_gnt_i) begin
          if (!last_idx)    state_d = XRD;
          else if (DUMP_FP) state_d = FRD;
          else              state_d = STOP;
        end
      end
      FRD: begin
        busy_o      = 1'b1;
        frf_raddr_o = idx_q;
        state_d     = FWR;
      end
      FWR: begin
        busy_o       = 1'b1;
        frf_raddr_o  = idx_q;
        mmio_req_o   = 1'b1;
        mmio_addr_o  = ADDR_FREG_DUMP;
        mmio_wdata_o = cap_vld_q ? wdata_q : frf_rdata_i;
        if (mmio_gnt_i) state_d = last_idx ? STOP : FRD;
      end
      STOP: begin
        busy_o      = 1'b1;
        mmio_req_o  = 1'b1;
        mmio_addr_o = ADDR_STOP_SIG;
        if (mmio_gnt_i) state_d = DONE;
      end
      TRAP: begin
        mmio_req_o   = 1'b1;
        mmio_addr_o  = ADDR_TRAP_SIG;
        mmio_wdata_o = cause_q;
        if (mmio_gnt_i) state_d = IDLE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mmio_we_o   = mmio_req_o;
  assign mmio_strb_o = mmio_req_o ? 8'hFF : 8'h00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= 5'd0;
      start_pend_q <= 1'b0;
      trap_pend_q  <= 1'b0;
      cap_vld_q    <= 1'b0;
      wdata_q      <= 64'h0;
      cause_q      <= 64'h0;
      cause_pend_q <= 64'h0;
    end else begin
      state_q <= state_d;
      if (trap_i) begin
        trap_pend_q  <= 1'b1;
        cause_pend_q <= trap_cause_i;
      end
      if (start_i && !busy_o) start_pend_q <= 1'b1;
      if (state_q == IDLE && state_d == TRAP) begin
        trap_pend_q <= 1'b0;
        cause_q     <= trap_i ? trap_cause_i : cause_pend_q;
      end
      if (state_q == IDLE && state_d == XRD) begin
        start_pend_q <= 1'b0;
        idx_q        <= 5'd1;
      end
      if (state_q == XWR || state_q == FWR) begin
        if (!cap_vld_q)
          wdata_q <= (state_q == XWR) ? xrf_rdata_i : frf_rdata_i;
        cap_vld_q <= !mmio_gnt_i;
        if (mmio_gnt_i)
          idx_q <= (state_q == XWR && last_idx) ? 5'd0 : idx_q + 5'd1;
      end else begin
        cap_vld_q <= 1'b0;
      end
    end
  end

endmodule
